// File: rtl/ahb_crypto_master_if.sv
// AHB-lite style bus bundle between the crypto job master and the crypto slave port.
interface ahb_crypto_master_if #(
  parameter int unsigned DATA_W = 128
);
  logic              HSELx;
  logic              HWRITE;
  logic              HREADY;
  logic [1:0]        HTRANS;
  logic [DATA_W-1:0] HWDATA;
  logic              HREADYOUT;
  logic              HRESP;

  modport master (
    output HSELx, HWRITE, HREADY, HTRANS, HWDATA,
    input  HREADYOUT, HRESP
  );

  modport slave (
    input  HSELx, HWRITE, HREADY, HTRANS, HWDATA,
    output HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_crypto_master.sv
// Issues one crypto job on the bus: key beat, wait beat, SRAM address beat, then N data blocks,
// with BUSY beats whenever the block source is empty, closed by a deselect (last-packet) beat.
module ahb_crypto_master #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [DATA_W-1:0] key,
  input  logic [ADDR_W-1:0] sram_base,
  input  logic [CNT_W-1:0]  num_blocks,
  input  logic [DATA_W-1:0] blk_data,
  input  logic              blk_valid,
  output logic              blk_pop,
  ahb_crypto_master_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {StIdle, StKey, StWait, StAddr, StData, StEnd, StErr} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] key_q;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              error_q;
  logic              accept;

  logic              hsel, hready;
  logic [1:0]        htrans;
  logic [DATA_W-1:0] hwdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    hsel    = 1'b0;
    hready  = 1'b0;
    htrans  = 2'b00;
    hwdata  = '0;
    blk_pop = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start && (num_blocks != '0)) begin
          accept  = 1'b1;
          state_d = StKey;
        end
      end
      StKey, StWait: begin
        hsel   = 1'b1;
        hready = 1'b1;
        busy   = 1'b1;
        htrans = 2'b10;
        hwdata = key_q;
        // The wait beat advances unconditionally; only the key beat honours HREADYOUT.
        if (bus.HRESP)                              state_d = StErr;
        else if (state_q == StWait || bus.HREADYOUT) state_d = (state_q == StKey) ? StWait : StAddr;
      end
      StAddr: begin
        hsel   = 1'b1;
        hready = 1'b1;
        busy   = 1'b1;
        htrans = 2'b10;
        hwdata = {{(DATA_W-ADDR_W){1'b0}}, base_q};
        if (bus.HRESP)          state_d = StErr;
        else if (bus.HREADYOUT) state_d = StData;
      end
      StData: begin
        hsel   = 1'b1;
        hready = 1'b1;
        busy   = 1'b1;
        if (blk_valid) begin
          htrans = 2'b11;
          hwdata = blk_data;
        end else begin
          htrans = 2'b01;
        end
        if (bus.HRESP) begin
          state_d = StErr;
        end else if (blk_valid && bus.HREADYOUT) begin
          blk_pop = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = StEnd;
        end
      end
      StEnd: begin
        hready  = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      key_q   <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        key_q   <= key;
        base_q  <= sram_base;
        cnt_q   <= num_blocks;
        error_q <= 1'b0;
      end else if (state_d == StErr) begin
        error_q <= 1'b1;
      end
    end
  end

  assign bus.HSELx  = hsel;
  assign bus.HWRITE = hsel;
  assign bus.HREADY = hready;
  assign bus.HTRANS = htrans;
  assign bus.HWDATA = hwdata;
  assign error      = error_q;

endmodule
